// File: rtl/snn_layer2_pkg.sv
// Shared types and sizing helpers for the layer-2 neuron bank scheduler.
package snn_layer2_pkg;

  localparam int unsigned DEF_N_IN      = 5;
  localparam int unsigned DEF_N_NEURONS = 10;
  localparam int unsigned DEF_T_STEPS   = 16;
  localparam int unsigned DEF_EXIT_CNT  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_FIRE,
    S_SAMPLE,
    S_DECIDE,
    S_DONE
  } state_e;

  // Counter must hold T_STEPS itself, hence the +1.
  function automatic int unsigned calc_cnt_w(input int unsigned t_steps);
    return $clog2(t_steps + 1);
  endfunction

  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_argmax_seq.sv
// Iterative argmax over per-neuron spike counts, one neuron per cycle from index 0.
// Strict greater-than keeps the lowest index on ties; all-zero counts yield index 0.
module snn_argmax_seq
  import snn_layer2_pkg::*;
#(
  parameter int unsigned N_NEURONS = DEF_N_NEURONS,
  parameter int unsigned CNT_W     = calc_cnt_w(DEF_T_STEPS),
  parameter int unsigned IDX_W     = calc_idx_w(N_NEURONS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                go,
  input  logic [N_NEURONS-1:0][CNT_W-1:0]     counts,
  output logic [IDX_W-1:0]                    idx_c,
  output logic                                valid_c
);

  logic [IDX_W-1:0] pos_q, pos_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             run_q, run_d;
  logic             take_c;
  logic             last_c;

  always_comb begin
    take_c     = counts[pos_q] > best_q;
    last_c     = run_q && (pos_q == IDX_W'(N_NEURONS - 1));
    idx_c      = take_c ? pos_q : best_idx_q;
    valid_c    = last_c;
    pos_d      = pos_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    run_d      = run_q;
    if (flush) begin
      run_d = 1'b0;
    end else if (go) begin
      pos_d      = '0;
      best_idx_d = '0;
      best_d     = '0;
      run_d      = 1'b1;
    end else if (run_q) begin
      if (take_c) begin
        best_d     = counts[pos_q];
        best_idx_d = pos_q;
      end
      if (last_c) begin
        run_d = 1'b0;
      end else begin
        pos_d = pos_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      run_q      <= run_d;
    end
  end

endmodule

// File: rtl/snn_layer2_scheduler.sv
// Timestep sequencer for the layer-2 neuron bank: clear, T_STEPS pulse steps, spike counting, argmax.
// Optional early exit on any count reaching EXIT_CNT: define SNN_LAYER2_EARLY_EXIT_EN.
module snn_layer2_scheduler
  import snn_layer2_pkg::*;
#(
  parameter int unsigned N_IN      = DEF_N_IN,
  parameter int unsigned N_NEURONS = DEF_N_NEURONS,
  parameter int unsigned T_STEPS   = DEF_T_STEPS,
  parameter int unsigned CNT_W     = calc_cnt_w(T_STEPS),
  parameter int unsigned IDX_W     = calc_idx_w(N_NEURONS)
`ifdef SNN_LAYER2_EARLY_EXIT_EN
  ,
  parameter int unsigned EXIT_CNT  = DEF_EXIT_CNT
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      spikes_in,
  output logic [N_IN-1:0]      pixels_out,
  output logic                 pulse,
  output logic                 neu_clr,
  input  logic [N_NEURONS-1:0] spk_in,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     class_out,
  output logic [CNT_W-1:0]     steps_run
);

  state_e                         state_q, state_d;
  logic [N_NEURONS-1:0][CNT_W-1:0] count_q, count_d, cnt_upd_c;
  logic [CNT_W-1:0]               step_q, step_d, step_inc_c;
  logic [N_IN-1:0]                pix_q, pix_d;
  logic [IDX_W-1:0]               class_q, class_d;
  logic [CNT_W-1:0]               steps_run_q, steps_run_d;
  logic in_ready_q, in_ready_d;
  logic pulse_q, pulse_d;
  logic neu_clr_q, neu_clr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic go_c, flush_c, exit_c;
  logic [IDX_W-1:0] arg_idx_c;
  logic             arg_valid_c;

  always_comb begin
    for (int i = 0; i < int'(N_NEURONS); i++) begin
      cnt_upd_c[i] = count_q[i] + CNT_W'(spk_in[i]);
    end
  end

`ifdef SNN_LAYER2_EARLY_EXIT_EN
  always_comb begin
    exit_c = 1'b0;
    for (int i = 0; i < int'(N_NEURONS); i++) begin
      if (cnt_upd_c[i] >= CNT_W'(EXIT_CNT)) exit_c = 1'b1;
    end
  end
`else
  assign exit_c = 1'b0;
`endif

  assign step_inc_c = step_q + CNT_W'(1);
  assign flush_c    = abort && (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    step_d      = step_q;
    pix_d       = pix_q;
    class_d     = class_q;
    steps_run_d = steps_run_q;
    go_c        = 1'b0;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        count_d = '0;
        step_d  = '0;
        state_d = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        if (in_valid && in_ready_q) begin
          pix_d   = spikes_in;
          state_d = S_FIRE;
        end
      end
      S_FIRE:    state_d = S_SAMPLE;
      S_SAMPLE: begin
        count_d = cnt_upd_c;
        step_d  = step_inc_c;
        if ((step_inc_c == CNT_W'(T_STEPS)) || exit_c) begin
          go_c    = 1'b1;
          state_d = S_DECIDE;
        end else begin
          state_d = S_WAIT_IN;
        end
      end
      // Result is latched on the edge into DONE so it is visible alongside done.
      S_DECIDE: begin
        if (arg_valid_c) begin
          class_d     = arg_idx_c;
          steps_run_d = step_q;
          state_d     = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (flush_c) begin
      state_d     = S_IDLE;
      go_c        = 1'b0;
      class_d     = class_q;
      steps_run_d = steps_run_q;
    end
    in_ready_d = (state_d == S_WAIT_IN);
    pulse_d    = (state_d == S_FIRE);
    neu_clr_d  = (state_d == S_CLEAR);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      step_q      <= '0;
      pix_q       <= '0;
      class_q     <= '0;
      steps_run_q <= '0;
      in_ready_q  <= 1'b0;
      pulse_q     <= 1'b0;
      neu_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      step_q      <= step_d;
      pix_q       <= pix_d;
      class_q     <= class_d;
      steps_run_q <= steps_run_d;
      in_ready_q  <= in_ready_d;
      pulse_q     <= pulse_d;
      neu_clr_q   <= neu_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  snn_argmax_seq #(
    .N_NEURONS (N_NEURONS),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (reset),
    .flush   (flush_c),
    .go      (go_c),
    .counts  (count_q),
    .idx_c   (arg_idx_c),
    .valid_c (arg_valid_c)
  );

  assign in_ready   = in_ready_q;
  assign pixels_out = pix_q;
  assign pulse      = pulse_q;
  assign neu_clr    = neu_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign class_out  = class_q;
  assign steps_run  = steps_run_q;

endmodule

// File: tb/tb_snn_layer2_scheduler.sv
// Scoreboard bench for snn_layer2_scheduler with a behavioural neuron bank driven by pulse.
module tb_snn_layer2_scheduler;

  localparam int N_IN  = 5;
  localparam int N_NEU = 10;
  localparam int CW    = 5;
  localparam int IW    = 4;
`ifdef SNN_LAYER2_EARLY_EXIT_EN
  localparam int FULL_STEPS = 8;
`else
  localparam int FULL_STEPS = 16;
`endif
  localparam int FULL_LAT = 1 + 3 * FULL_STEPS + N_NEU + 1;
  localparam int STD_LAT  = 1 + 3 * 16 + N_NEU + 1;

  typedef struct {
    int cls;
    int steps;
    int lat;
    int pulses;
    int t0;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  spikes_in;
  logic [N_IN-1:0]  pixels_out;
  logic             pulse;
  logic             neu_clr;
  logic [N_NEU-1:0] spk_in = '0;
  logic             busy;
  logic             done;
  logic [IW-1:0]    class_out;
  logic [CW-1:0]    steps_run;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mode = 0;
  int vmode = 0;
  int vcnt = 0;
  int pulse_cnt = 0;
  int clr_cnt = 0;
  int done_seen = 0;
  logic [N_IN-1:0] exp_pix = '0;
  logic prev_pulse = 1'b0;
  exp_t exq[$];

  snn_layer2_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .spikes_in  (spikes_in),
    .pixels_out (pixels_out),
    .pulse      (pulse),
    .neu_clr    (neu_clr),
    .spk_in     (spk_in),
    .busy       (busy),
    .done       (done),
    .class_out  (class_out),
    .steps_run  (steps_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [N_NEU-1:0] pat(input int m, input int p);
    logic [N_NEU-1:0] v;
    v = '0;
    case (m)
      0: v[3] = 1'b1;
      1: if (p <= 5) begin v[2] = 1'b1; v[7] = 1'b1; end
      3: begin
        if (p <= 7) v[6] = 1'b1;
        if (p <= 3) v[1] = 1'b1;
      end
      4: if (p <= 2) v[3] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Neuron bank model: spike vector appears the cycle after each pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy) begin
      pulse_cnt <= 0;
      clr_cnt   <= 0;
    end else begin
      if (pulse) pulse_cnt <= pulse_cnt + 1;
      if (neu_clr) clr_cnt <= clr_cnt + 1;
    end
    spk_in <= pulse ? pat(mode, pulse_cnt + 1) : '0;
    if (in_valid && in_ready) exp_pix <= spikes_in;
  end

  always @(negedge clk) begin
    vcnt++;
    in_valid  = (vmode == 0) || (vcnt % 3 == 0);
    spikes_in = N_IN'(vcnt * 3 + 1);
  end

  // Monitor: pixel stability around each pulse, result scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (pulse) begin
        check("pix_fire", int'(pixels_out), int'(exp_pix));
        check("fire_excl", int'({neu_clr, done}), 0);
      end
      if (prev_pulse) check("pix_sample", int'(pixels_out), int'(exp_pix));
      if (done) begin
        done_seen++;
        if (exq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exq.pop_front();
          check("class_out", int'(class_out), e.cls);
          check("steps_run", int'(steps_run), e.steps);
          check("pulse_count", pulse_cnt, e.pulses);
          check("clear_count", clr_cnt, 1);
          if (e.lat > 0) check("latency", cyc - e.t0, e.lat);
        end
      end
    end
    prev_pulse = pulse && reset;
  end

  task automatic run(input int m, input int cls, input int steps, input int lat, input bit poke);
    exp_t e;
    int base;
    base = done_seen;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    e.cls = cls; e.steps = steps; e.lat = lat; e.pulses = steps; e.t0 = cyc;
    exq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_seen != base) break;
    end
    if (done_seen == base) begin
      check("done_timeout", done_seen, base + 1);
      if (exq.size() != 0) void'(exq.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    int  base;
    bit  found;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", int'({in_ready, pulse, neu_clr, busy, done}), 0);
    check("rst_class", int'(class_out), 0);
    check("rst_steps", int'(steps_run), 0);
    check("rst_pix", int'(pixels_out), 0);
    #3 reset = 1'b1;

    run(0, 3, FULL_STEPS, FULL_LAT, 1'b0);

    // Asynchronous reset while the bank is being pulsed.
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pulse) begin found = 1'b1; break; end
    end
    check("reach_fire", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_fire_pulse", int'(pulse), 0);
    check("rst_fire_busy", int'(busy), 0);
    check("rst_fire_class", int'(class_out), 0);
    @(negedge clk);
    #3 reset = 1'b1;

    run(0, 3, FULL_STEPS, FULL_LAT, 1'b0);

    // Abort in the FIRE cycle of step 9.
    base = done_seen;
    @(negedge clk);
    mode  = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pulse && pulse_cnt == 8) begin found = 1'b1; break; end
    end
    check("reach_step9", int'(found), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", int'(busy), 0);
    check("abort_class", int'(class_out), 3);
    check("abort_steps", int'(steps_run), FULL_STEPS);
    repeat (80) @(negedge clk);
    check("abort_no_done", done_seen, base);

    run(1, 2, 16, STD_LAT, 1'b0);
    run(2, 0, 16, STD_LAT, 1'b0);

    vmode = 1;
    run(3, 6, 16, 0, 1'b1);
    vmode = 0;

    check("queue_empty", exq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/snn_layer2_scheduler.md
Name: snn_layer2_scheduler

Overview:
- Timestep sequencer for the layer-2 neuron bank: N_NEURONS parallel MAC+NCHU neuron instances sharing one pixel bus, one pulse strobe and one clear.
- Per inference it:
  - clears membranes;
  - runs T_STEPS timesteps, each taking one 5-bit spike vector from layer 1 and issuing one pulse;
  - counts output spikes per neuron;
  - picks the winning class by sequential argmax.
- Sits between the layer-1 spike output and the classification result register.

Parameters:
- N_IN, 5, spike inputs per neuron (pixel bus width)
- N_NEURONS, 10, neurons in the bank / number of classes
- T_STEPS, 16, timesteps per inference (≥1)
- CNT_W, $clog2(T_STEPS+1), per-neuron spike counter width
- IDX_W, $clog2(N_NEURONS), class index width
- EXIT_CNT, 8, early-exit spike threshold (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin inference; sampled only in IDLE
- abort  in  1  synchronous abort, returns to IDLE
- in_valid  in  1  layer-1 spike vector valid
- in_ready  out  1  scheduler accepts vector this cycle
- spikes_in  in  N_IN  layer-1 spike vector
- pixels_out  out  N_IN  registered spike vector to neuron bank
- pulse  out  1  one-cycle integrate strobe to all neurons
- neu_clr  out  1  one-cycle active-high membrane clear to all neurons
- spk_in  in  N_NEURONS  neuron spike outputs
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle result strobe
- class_out  out  IDX_W  winning neuron index, held until next start
- steps_run  out  CNT_W  timesteps executed in the last inference

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE; in_ready, pulse, neu_clr, busy, done = 0.
  - pixels_out, class_out, steps_run, step counter, all spike counters = 0.
- FSM states: IDLE, CLEAR, WAIT_IN, FIRE, SAMPLE, DECIDE, DONE.
- IDLE:
  - start=1 → CLEAR.
  - start outside IDLE is ignored.
- CLEAR (1 cycle):
  - neu_clr=1.
  - Spike counters and step counter cleared.
  - → WAIT_IN.
- WAIT_IN:
  - in_ready=1.
  - On in_valid & in_ready: latch spikes_in into pixels_out, → FIRE.
  - Otherwise hold; no timeout.
- FIRE (1 cycle):
  - pulse=1.
  - pixels_out stable from WAIT_IN exit through SAMPLE.
  - → SAMPLE.
- SAMPLE (1 cycle):
  - Sample spk_in, valid one cycle after pulse.
  - count[i] += spk_in[i].
  - Counters cannot overflow (CNT_W covers T_STEPS).
  - step counter increments.
  - If step counter reaches T_STEPS after the increment → DECIDE; else → WAIT_IN.
- DECIDE:
  - Sequential argmax, one neuron per cycle: N_NEURONS cycles, index 0 first.
  - Strict greater-than compare, so ties go to the lowest index.
  - All-zero counts → class 0.
  - → DONE.
- DONE (1 cycle):
  - done=1; class_out and steps_run updated this same cycle.
  - → IDLE.
- Minimum latency, start to done, with in_valid held high: 1 + 3·T_STEPS + N_NEURONS + 1 cycles.
- Abort:
  - abort=1 in any non-IDLE state → IDLE next cycle.
  - No done; class_out/steps_run keep previous values.
  - Abort has priority over all other transitions.
  - Abort in IDLE has no effect.
- Outputs pulse, neu_clr and done are registered, glitch-free, and never asserted simultaneously.
- Async reset mid-inference: everything returns to reset values immediately. Neuron membranes are not cleared by the scheduler until the next CLEAR.

Optional Feature:
- Macro: SNN_LAYER2_EARLY_EXIT_EN.
- Defined: in SAMPLE, if any count[i] after the update is ≥ EXIT_CNT, go → DECIDE regardless of the step counter; steps_run reports the actual steps.
- Undefined: always exactly T_STEPS timesteps; EXIT_CNT unused; no comparator logic synthesized.

Decomposition:
- Package snn_layer2_pkg:
  - state enum (7 states);
  - default N_IN, N_NEURONS, T_STEPS constants;
  - CNT_W/IDX_W derivation functions.
- One sub-module snn_argmax_seq holds the iterative max search:
  - inputs: counts vector, go;
  - outputs: idx, valid;
  - N_NEURONS-cycle search, ties go to the lowest index.
- The scheduler keeps the FSM, counters and handshake.

Test Plan:
- Reset while busy in FIRE → pulse=0, busy=0, class_out=0 on the same edge; next start runs a full inference normally.
- T_STEPS=16, in_valid always 1, neuron model spikes neuron 3 every step, others never → exactly 16 pulses, 1 neu_clr, done at cycle 1+48+10+1=60 after start, class_out=3, steps_run=16.
- Neurons 2 and 7 both reach count 5 → class_out=2 (lowest-index tie); all-zero spikes → class_out=0.
- in_valid toggled 1-0-0-1… → pulse issued only after each accepted vector; pixels_out equals the accepted spikes_in value and is stable during FIRE/SAMPLE; start pulsed while busy is ignored.
- abort asserted during step 9 → IDLE next cycle, no done, class_out retains the prior result 3.
- With SNN_LAYER2_EARLY_EXIT_EN and EXIT_CNT=8, neuron 5 spiking every step → DECIDE after step 8, steps_run=8, class_out=5; without the macro, steps_run=16.
